// File: rtl/vram_tile_snooper.sv
// rtl/vram_tile_snooper.sv - VRAM tile-data write snooper emitting {tile_index, CRC-16} entries; define VRAM_SNOOP_FIFO_EN for a 4-entry output FIFO

// Byte-wide CRC-16/CCITT-FALSE step (poly 0x1021, MSB-first, no reflection)
module vram_tile_crc16 (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  logic [15:0] s0, s1, s2;

  // Byte-swap, fold the data in, then apply the table-free 0x1021 terms
  assign s0    = {crc_i[7:0], crc_i[15:8]} ^ {8'h00, data_i};
  assign s1    = s0 ^ {12'h000, s0[7:4]};
  assign s2    = s1 ^ {s1[3:0], 12'h000};
  assign crc_o = s2 ^ {3'b000, s2[7:0], 5'b00000};
endmodule

module vram_tile_snooper #(
  parameter logic [15:0] VRAM_BASE  = 16'h8000,
  parameter int          TILE_COUNT = 384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_data,
  input  logic        bus_wr,
  input  logic        cfg_enable,
  input  logic        replace_active,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [8:0]  tile_index,
  output logic [15:0] tile_sig,
  output logic [8:0]  cur_tile,
  output logic [3:0]  cur_offset,
  output logic [7:0]  drop_count
);
  localparam logic [16:0] SPACE_LO = {1'b0, VRAM_BASE};
  localparam logic [16:0] SPACE_HI = SPACE_LO + 17'(TILE_COUNT * 16);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

  state_t      state_q, state_d;
  logic [8:0]  cur_tile_q, cur_tile_d;
  logic [3:0]  cur_offset_q, cur_offset_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  drop_count_q;

  logic        in_space, snoop_en, snoop;
  logic [8:0]  wr_index;
  logic [3:0]  wr_offset;
  logic        wr_match;
  logic [15:0] crc_seed, crc_next;
  logic        push, pop, drop;

  assign in_space  = ({1'b0, bus_addr} >= SPACE_LO) && ({1'b0, bus_addr} < SPACE_HI);
  assign snoop_en  = cfg_enable && !replace_active;
  assign snoop     = bus_wr && snoop_en && in_space;
  assign wr_index  = 9'((bus_addr - VRAM_BASE) >> 4);
  assign wr_offset = bus_addr[3:0];
  assign wr_match  = (wr_index == cur_tile_q) && (wr_offset == cur_offset_q);

  // Only an in-order continuation keeps the running CRC; any start reseeds
  assign crc_seed = ((state_q == S_COLLECT) && (wr_offset != 4'd0)) ? crc_q : 16'hFFFF;

  vram_tile_crc16 u_crc (
    .crc_i  (crc_seed),
    .data_i (bus_data),
    .crc_o  (crc_next)
  );

  // Collection state, tile position and running CRC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_tile_q   <= '0;
      cur_offset_q <= '0;
      crc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_tile_q   <= cur_tile_d;
      cur_offset_q <= cur_offset_d;
      crc_q        <= crc_d;
    end
  end

  // Next-state: start on offset 0, follow in-order bytes, abort on anything else
  always_comb begin
    state_d      = state_q;
    cur_tile_d   = cur_tile_q;
    cur_offset_d = cur_offset_q;
    crc_d        = crc_q;
    push         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (snoop && (wr_offset == 4'd0)) begin
          state_d      = S_COLLECT;
          cur_tile_d   = wr_index;
          cur_offset_d = 4'd1;
          crc_d        = crc_next;
        end
      end
      S_COLLECT: begin
        if (!snoop_en) begin
          state_d = S_IDLE;
        end else if (snoop) begin
          if (wr_match) begin
            crc_d        = crc_next;
            cur_offset_d = cur_offset_q + 4'd1;
            if (cur_offset_q == 4'd15) state_d = S_EMIT;
          end else if (wr_offset == 4'd0) begin
            cur_tile_d   = wr_index;
            cur_offset_d = 4'd1;
            crc_d        = crc_next;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        push    = 1'b1;
        state_d = S_IDLE;
        if (snoop && (wr_offset == 4'd0)) begin
          state_d      = S_COLLECT;
          cur_tile_d   = wr_index;
          cur_offset_d = 4'd1;
          crc_d        = crc_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef VRAM_SNOOP_FIFO_EN
  logic [8:0]  fifo_index_q [4];
  logic [15:0] fifo_sig_q   [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        accept;

  assign pop    = (count_q != 3'd0) && tile_ready;
  assign accept = push && ((count_q != 3'd4) || pop);
  assign drop   = push && !accept;

  // Circular 4-entry buffer; a pop in the same cycle frees room for a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_index_q[i] <= '0;
        fifo_sig_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        fifo_index_q[wr_ptr_q] <= cur_tile_q;
        fifo_sig_q[wr_ptr_q]   <= crc_q;
        wr_ptr_q               <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, accept} - {2'b00, pop};
    end
  end

  assign tile_valid = (count_q != 3'd0);
  assign tile_index = fifo_index_q[rd_ptr_q];
  assign tile_sig   = fifo_sig_q[rd_ptr_q];
`else
  logic        out_valid_q;
  logic [8:0]  out_index_q;
  logic [15:0] out_sig_q;

  assign pop  = out_valid_q && tile_ready;
  assign drop = push && out_valid_q && !tile_ready;

  // Single holding register; a push during a handshake replaces the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_sig_q   <= '0;
    end else if (push && !drop) begin
      out_valid_q <= 1'b1;
      out_index_q <= cur_tile_q;
      out_sig_q   <= crc_q;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign tile_valid = out_valid_q;
  assign tile_index = out_index_q;
  assign tile_sig   = out_sig_q;
`endif

  // Saturating count of completed tiles lost to a full output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
    end else if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign cur_tile   = cur_tile_q;
  assign cur_offset = cur_offset_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_vram_tile_snooper.sv
// tb/tb_vram_tile_snooper.sv - directed self-checking bench for vram_tile_snooper
module tb_vram_tile_snooper;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_wr;
  logic        cfg_enable;
  logic        replace_active;
  logic        tile_valid;
  logic        tile_ready;
  logic [8:0]  tile_index;
  logic [15:0] tile_sig;
  logic [8:0]  cur_tile;
  logic [3:0]  cur_offset;
  logic [7:0]  drop_count;

  int n_pass  = 0;
  int n_total = 0;
  int accepted = 0;
  int acc_snap;

  vram_tile_snooper dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_addr       (bus_addr),
    .bus_data       (bus_data),
    .bus_wr         (bus_wr),
    .cfg_enable     (cfg_enable),
    .replace_active (replace_active),
    .tile_valid     (tile_valid),
    .tile_ready     (tile_ready),
    .tile_index     (tile_index),
    .tile_sig       (tile_sig),
    .cur_tile       (cur_tile),
    .cur_offset     (cur_offset),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && tile_valid && tile_ready) accepted <= accepted + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_sig(input logic [7:0] base);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      c = c ^ {base + 8'(i), 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_data = d;
    bus_wr   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_wr = 1'b0;
    end
  endtask

  task automatic write_tile(input logic [8:0] idx, input logic [7:0] base);
    for (int i = 0; i < 16; i++)
      write_byte(16'h8000 + {3'b000, idx, 4'h0} + 16'(i), base + 8'(i));
  endtask

  task automatic expect_entry(input string tag, input logic [8:0] idx, input logic [7:0] base);
    idle(1);
    check({tag, "_valid_early"}, tile_valid, 1'b0);
    idle(1);
    check({tag, "_valid"}, tile_valid, 1'b1);
    check({tag, "_index"}, tile_index, idx);
    check({tag, "_sig"}, tile_sig, model_sig(base));
  endtask

  initial begin
    rst_n = 1'b0; bus_addr = '0; bus_data = '0; bus_wr = 1'b0;
    cfg_enable = 1'b1; replace_active = 1'b0; tile_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", tile_valid, 1'b0);
    check("rst_index", tile_index, 9'd0);
    check("rst_sig", tile_sig, 16'd0);
    check("rst_cur_tile", cur_tile, 9'd0);
    check("rst_cur_offset", cur_offset, 4'd0);
    check("rst_drop", drop_count, 8'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    write_tile(9'd0, 8'h00);
    expect_entry("tile0", 9'd0, 8'h00);
    idle(2);
    check("tile0_count", accepted, 1);

    write_byte(16'h9800, 8'h11);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) write_byte(16'h9800, 8'h55);
      write_byte(16'h97F0 + 16'(i), 8'hA0 + 8'(i));
    end
    expect_entry("tile383", 9'd383, 8'hA0);
    idle(2);

    for (int i = 0; i < 7; i++) write_byte(16'h8010 + 16'(i), 8'(i));
    write_byte(16'h8018, 8'h08);
    idle(5);
    check("abort_skip_count", accepted, 2);

    for (int i = 0; i < 7; i++) write_byte(16'h8010 + 16'(i), 8'(i));
    write_byte(16'h8020, 8'h20);
    idle(1);
    check("restart_cur_tile", cur_tile, 9'd2);
    check("restart_cur_offset", cur_offset, 4'd1);
    idle(5);
    check("abort_restart_count", accepted, 2);

    for (int i = 0; i < 16; i++) begin
      write_byte(16'h8050 + 16'(i), 8'h30 + 8'(i));
      replace_active = (i == 8);
    end
    idle(5);
    check("replace_abort_count", accepted, 2);
    write_tile(9'd5, 8'h30);
    expect_entry("rewrite5", 9'd5, 8'h30);
    idle(2);
    check("rewrite5_count", accepted, 3);

    tile_ready = 1'b0;
    write_tile(9'd10, 8'h40);
    write_tile(9'd11, 8'h50);
    write_tile(9'd12, 8'h60);
    idle(3);
    check("held_valid", tile_valid, 1'b1);
    check("held_index", tile_index, 9'd10);
    check("held_sig", tile_sig, model_sig(8'h40));
`ifdef VRAM_SNOOP_FIFO_EN
    check("held_drop", drop_count, 8'd0);
    tile_ready = 1'b1;
    idle(1);
    check("fifo_2nd_index", tile_index, 9'd11);
    check("fifo_2nd_sig", tile_sig, model_sig(8'h50));
    idle(1);
    check("fifo_3rd_index", tile_index, 9'd12);
    check("fifo_3rd_sig", tile_sig, model_sig(8'h60));
    idle(1);
    check("fifo_empty", tile_valid, 1'b0);
    check("fifo_count", accepted, 6);
`else
    check("held_drop", drop_count, 8'd2);
    tile_ready = 1'b1;
    idle(1);
    check("reg_empty", tile_valid, 1'b0);
    check("reg_count", accepted, 4);
`endif

    for (int i = 0; i < 10; i++) write_byte(16'h8140 + 16'(i), 8'(i));
    @(negedge clk);
    bus_wr = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_valid", tile_valid, 1'b0);
    check("mid_rst_index", tile_index, 9'd0);
    check("mid_rst_sig", tile_sig, 16'd0);
    check("mid_rst_cur_tile", cur_tile, 9'd0);
    check("mid_rst_cur_offset", cur_offset, 4'd0);
    check("mid_rst_drop", drop_count, 8'd0);
    idle(2);
    rst_n = 1'b1;

    acc_snap = accepted;
    write_tile(9'd21, 8'h70);
    @(negedge clk);
    bus_wr = 1'b0;
    rst_n  = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("emit_rst_valid", tile_valid, 1'b0);
    check("emit_rst_count", accepted, acc_snap);

    write_tile(9'd22, 8'h80);
    expect_entry("clean22", 9'd22, 8'h80);
    idle(2);

    tile_ready = 1'b0;
`ifdef VRAM_SNOOP_FIFO_EN
    for (int k = 0; k < 304; k++) write_tile(9'd7, 8'(k));
`else
    for (int k = 0; k < 301; k++) write_tile(9'd7, 8'(k));
`endif
    idle(3);
    check("drop_saturate", drop_count, 8'd255);
    check("drop_head_index", tile_index, 9'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
